// File: rtl/decoder_pkg.sv
// Shared types for the registered binary decoder: operating modes, FSM states
// and the output-width helper.
package decoder_pkg;

  typedef enum logic [1:0] {
    DIRECT    = 2'b00,
    SCAN_CONT = 2'b01,
    SCAN_ONCE = 2'b10,
    RSVD      = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SCAN  = 2'b01,
    PAUSE = 2'b10
  } state_e;

  localparam int MAX_IN_BITS = 6;

  function automatic int out_w(input int in_bits);
    return 1 << in_bits;
  endfunction

endpackage

// File: rtl/binary_decoder_seq_dwell_timer.sv
// Dwell counter for the scan sequencer: counts enabled cycles and flags the
// last cycle of each line's dwell.
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick_en,
  output logic expire
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire = tick_en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick_en) begin
      cnt_d = expire ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/binary_decoder_seq.sv
// Registered N-to-2^N decoder with direct decode, a dwell-timed scan sequencer
// (single pass or continuous) and selectable output polarity.
module binary_decoder_seq
  import decoder_pkg::*;
#(
  parameter int IN_BITS    = 2,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [1:0]                  mode,
  input  logic [IN_BITS-1:0]          in,
  input  logic                        start,
  input  logic                        stop,
  output logic [out_w(IN_BITS)-1:0]   out,
  output logic [IN_BITS-1:0]          index,
  output logic                        busy,
  output logic                        done
);

  localparam int OUT_W = out_w(IN_BITS);
  localparam logic [OUT_W-1:0]   IDLE_PAT = ACTIVE_LOW ? '1 : '0;
  localparam logic [OUT_W-1:0]   ONE      = OUT_W'(1);
  localparam logic [IN_BITS-1:0] LAST_IDX = IN_BITS'(OUT_W - 1);

  state_e               state_q, state_d;
  mode_e                run_mode_q, run_mode_d;
  logic [IN_BITS-1:0]   index_q, index_d;
  logic [OUT_W-1:0]     out_q, out_d;
  logic                 done_q, done_d;
  logic                 line_on;
  logic                 tmr_clr, tmr_tick, tmr_expire;
  mode_e                mode_s;
  logic                 scan_req;

  assign mode_s   = mode_e'(mode);
  assign scan_req = (mode_s == SCAN_CONT) || (mode_s == SCAN_ONCE);
  // The edge that leaves PAUSE re-shows the line, so it counts toward the dwell.
  assign tmr_tick = (state_q != IDLE) && en && !stop;

  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .tick_en (tmr_tick),
    .expire  (tmr_expire)
  );

  always_comb begin
    state_d    = state_q;
    run_mode_d = run_mode_q;
    index_d    = index_q;
    done_d     = 1'b0;
    tmr_clr    = 1'b0;
    line_on    = 1'b0;
    case (state_q)
      IDLE: begin
        if (scan_req) begin
          if (start && !stop && en) begin
            state_d    = SCAN;
            run_mode_d = mode_s;
            index_d    = '0;
            tmr_clr    = 1'b1;
            line_on    = 1'b1;
          end
        end else if (en) begin
          index_d = in;
          line_on = 1'b1;
        end
      end
      SCAN, PAUSE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!en) begin
          state_d = PAUSE;
        end else begin
          state_d = SCAN;
          line_on = 1'b1;
          if (tmr_expire) begin
            if ((index_q == LAST_IDX) && (run_mode_q == SCAN_ONCE)) begin
              state_d = IDLE;
              done_d  = 1'b1;
              line_on = 1'b0;
            end else begin
              index_d = index_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    out_d = (line_on ? (ONE << index_d) : '0) ^ IDLE_PAT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      run_mode_q <= DIRECT;
      index_q    <= '0;
      out_q      <= IDLE_PAT;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_mode_q <= run_mode_d;
      index_q    <= index_d;
      out_q      <= out_d;
      done_q     <= done_d;
    end
  end

  assign out   = out_q;
  assign index = index_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;

endmodule

// File: tb/tb_binary_decoder_seq.sv
// Randomized and directed bench for binary_decoder_seq: a 2-bit/DWELL=4 instance
// and a 3-bit/DWELL=1/active-low instance share one stimulus stream.
module tb_binary_decoder_seq;

  logic       clk;
  logic       rst, en, start, stop;
  logic [1:0] mode;
  logic [2:0] sel;

  logic [3:0] out_a;
  logic [1:0] index_a;
  logic       busy_a, done_a;
  logic [7:0] out_b;
  logic [2:0] index_b;
  logic       busy_b, done_b;

  binary_decoder_seq #(.IN_BITS(2), .DWELL(4), .ACTIVE_LOW(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(sel[1:0]),
    .start(start), .stop(stop), .out(out_a), .index(index_a),
    .busy(busy_a), .done(done_a)
  );

  binary_decoder_seq #(.IN_BITS(3), .DWELL(1), .ACTIVE_LOW(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(sel),
    .start(start), .stop(stop), .out(out_b), .index(index_b),
    .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a scan is described by how many cycles it has shown a
  // line so far; the active line is that count divided by the dwell.
  int cfg_ow[2] = '{4, 8};
  int cfg_dw[2] = '{4, 1};
  int cfg_al[2] = '{0, 1};
  int m_busy[2], m_once[2], m_elapsed[2], m_index[2], m_onehot[2], m_done[2];

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int exp_out(input int d);
    return m_onehot[d] ^ (cfg_al[d] != 0 ? ((1 << cfg_ow[d]) - 1) : 0);
  endfunction

  task automatic model_edge(input int d);
    int ow, dw;
    ow = cfg_ow[d];
    dw = cfg_dw[d];
    if (rst) begin
      m_busy[d] = 0; m_once[d] = 0; m_elapsed[d] = 0;
      m_index[d] = 0; m_onehot[d] = 0; m_done[d] = 0;
    end else begin
      m_done[d] = 0;
      if (m_busy[d] == 0) begin
        if (mode == 2'd1 || mode == 2'd2) begin
          m_onehot[d] = 0;
          if (start && !stop && en) begin
            m_busy[d] = 1; m_once[d] = (mode == 2'd2);
            m_elapsed[d] = 1; m_index[d] = 0; m_onehot[d] = 1;
          end
        end else if (en) begin
          m_index[d]  = int'(sel) % ow;
          m_onehot[d] = 1 << m_index[d];
        end else begin
          m_onehot[d] = 0;
        end
      end else if (stop) begin
        m_busy[d] = 0; m_onehot[d] = 0;
      end else if (!en) begin
        m_onehot[d] = 0;
      end else if (m_once[d] != 0 && m_elapsed[d] == ow * dw) begin
        m_busy[d] = 0; m_done[d] = 1; m_onehot[d] = 0;
      end else begin
        m_elapsed[d]++;
        m_index[d]  = ((m_elapsed[d] - 1) / dw) % ow;
        m_onehot[d] = 1 << m_index[d];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d);
    #1;
    chk_val("out_a",   32'(out_a),   exp_out(0));
    chk_val("index_a", 32'(index_a), m_index[0]);
    chk_val("busy_a",  32'(busy_a),  m_busy[0]);
    chk_val("done_a",  32'(done_a),  m_done[0]);
    chk_val("out_b",   32'(out_b),   exp_out(1));
    chk_val("index_b", 32'(index_b), m_index[1]);
    chk_val("busy_b",  32'(busy_b),  m_busy[1]);
    chk_val("done_b",  32'(done_b),  m_done[1]);
  endtask

  initial begin
    int exp_a;
    rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0; sel = 3'd0;
    step();
    chk_val("rst_out_a", 32'(out_a), 32'h0);
    chk_val("rst_out_b", 32'(out_b), 32'hFF);
    chk_val("rst_busy_a", 32'(busy_a), 32'h0);
    rst = 1'b0;

    // Direct decode, one cycle of latency
    en = 1'b1; mode = 2'd0;
    for (int i = 0; i < 4; i++) begin
      sel = 3'(i);
      step();
      chk_val("direct_out_a", 32'(out_a), 32'd1 << i);
    end
    en = 1'b0;
    step();
    chk_val("direct_en0_a", 32'(out_a), 32'h0);
    en = 1'b1; sel = 3'd5;
    step();
    chk_val("direct_lo_b", 32'(out_b), 32'hDF);

    // Single pass scan
    mode = 2'd2; start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      step();
      start = 1'b0;
      chk_val("once_out_a", 32'(out_a), (c <= 16) ? (32'd1 << ((c - 1) / 4)) : 32'h0);
      chk_val("once_done_a", 32'(done_a), (c == 17) ? 32'd1 : 32'd0);
      chk_val("once_busy_a", 32'(busy_a), (c <= 16) ? 32'd1 : 32'd0);
      chk_val("once_out_b", 32'(out_b), (c <= 8) ? (32'hFF ^ (32'd1 << (c - 1))) : 32'hFF);
      chk_val("once_done_b", 32'(done_b), (c == 9) ? 32'd1 : 32'd0);
    end

    // Continuous scan with wrap, then stop
    mode = 2'd1; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      if (c == 20) stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      chk_val("cont_done_a", 32'(done_a), 32'h0);
      if (c == 17) begin
        chk_val("cont_wrap_a", 32'(out_a), 32'h1);
        chk_val("cont_busy_a", 32'(busy_a), 32'h1);
      end
      if (c == 20) begin
        chk_val("cont_stop_out_a", 32'(out_a), 32'h0);
        chk_val("cont_stop_busy_a", 32'(busy_a), 32'h0);
      end
    end

    // Single pass with a three-cycle pause on line 1
    mode = 2'd2; start = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      en = (c >= 7 && c <= 9) ? 1'b0 : 1'b1;
      step();
      start = 1'b0;
      if (c >= 7 && c <= 9)  exp_a = 0;
      else if (c <= 6)       exp_a = 1 << ((c - 1) / 4);
      else if (c <= 19)      exp_a = 1 << ((c - 4) / 4);
      else                   exp_a = 0;
      chk_val("pause_out_a", 32'(out_a), exp_a);
      chk_val("pause_busy_a", 32'(busy_a), (c <= 19) ? 32'd1 : 32'd0);
      chk_val("pause_done_a", 32'(done_a), (c == 20) ? 32'd1 : 32'd0);
    end
    en = 1'b1;

    // Reset in the middle of a scan
    mode = 2'd2; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      if (c == 10) rst = 1'b1;
      step();
      start = 1'b0;
    end
    chk_val("midrst_out_a", 32'(out_a), 32'h0);
    chk_val("midrst_index_a", 32'(index_a), 32'h0);
    chk_val("midrst_busy_a", 32'(busy_a), 32'h0);
    chk_val("midrst_out_b", 32'(out_b), 32'hFF);
    rst = 1'b0;

    // start+stop together, and start with en low
    start = 1'b1; stop = 1'b1;
    step();
    chk_val("startstop_busy_a", 32'(busy_a), 32'h0);
    stop = 1'b0; en = 1'b0;
    step();
    chk_val("start_en0_busy_a", 32'(busy_a), 32'h0);
    start = 1'b0; en = 1'b1;
    step();
    chk_val("start_en0_after_a", 32'(busy_a), 32'h0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(63) == 0);
      en    = ($urandom_range(7) != 0);
      mode  = 2'($urandom_range(3));
      sel   = 3'($urandom_range(7));
      start = ($urandom_range(15) == 0);
      stop  = ($urandom_range(31) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
